pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter and fetch sequencer that drives the 10-bit PC into the branch-resolution logic and consumes the next-PC it returns. It owns the PC register and fetches each instruction from instruction memory through a req/ack handshake. It presents the fetched instruction to decode/execute, commits the returned NPC, and halts cleanly at a programmed last address by asserting `halted`; it never ends simulation. It sits between instruction memory and the datapath, closing the PC → branch logic → NPC loop.

## Interface
- `PC_W`, 10, width of PC, NPC and memory address
- `RESET_PC`, 0, PC value loaded on reset
- `LAST_PC`, 59, address of the final instruction; committing it halts the sequencer
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin execution from the current PC; sampled only in IDLE
- `imem_req`  out  1  fetch request; held high until ack
- `imem_addr`  out  PC_W  fetch address; equals `pc` while `imem_req` is high
- `imem_ack`  in  1  memory has valid `imem_rdata` this cycle
- `imem_rdata`  in  32  instruction word
- `pc`  out  PC_W  current PC, fed to the branch logic
- `instr`  out  32  latched instruction word
- `instr_valid`  out  1  `instr` is valid and awaiting commit
- `npc`  in  PC_W  next PC from the branch logic
- `npc_valid`  in  1  execute has resolved `npc` for the current instruction
- `halted`  out  1  `LAST_PC` committed; sticky until reset
- `retired`  out  16  count of committed instructions, saturating at 16'hFFFF

## Operation
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE: no request. `start`=1 → FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On a cycle with `imem_ack`=1, latch `imem_rdata` into `instr` and go to EXEC. Otherwise stay in FETCH with the request held.
- EXEC: `instr_valid`=1. On `npc_valid`=1, increment `retired` (saturating). Then:
  - if `pc`==`LAST_PC`: go to HALT; `pc` is unchanged.
  - otherwise: `pc` ← `npc` and go to FETCH.
- HALT: `halted`=1, `instr_valid`=0, no requests. Only `rst` leaves HALT.
- PC arithmetic is owned by the branch logic. `npc` is taken verbatim at PC_W bits, so wrap-around is whatever the branch logic produced.
- Ignored inputs:
  - `imem_ack` outside FETCH.
  - `npc_valid` outside EXEC.
  - `start` outside IDLE.
- `imem_rdata` is sampled only on the ack edge. Later changes do not alter `instr`.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0
  - `imem_req`=0, `halted`=0, `retired`=0
  - state=IDLE
- `rst` takes priority over every other input in every state. Reset mid-fetch drops `imem_req` on the next edge, and any later ack is ignored.
- Outputs are registered or decoded from the state register only. There is no combinational path from input to output.
- `start` sampled high at edge N → `imem_req`=1 in cycle N+1.
- Ack in the first request cycle: `instr_valid`=1 in the following cycle.
- `npc_valid` at edge M → new `pc` and `imem_req`=1 in cycle M+1.
- Minimum throughput is 2 cycles per instruction: one FETCH cycle and one EXEC cycle, with zero-wait memory and immediate `npc_valid`.
- Memory wait states extend FETCH. Execute stalls extend EXEC. `pc` and `instr` are stable throughout either stall.
- `halted` rises the cycle after the edge that commits `LAST_PC`.

## Test plan
- Reset and start:
  - Stimulus: apply `rst`, release, pulse `start`; zero-wait memory.
  - Required: `imem_req`=1 with `imem_addr`=0 one cycle after `start`; `instr_valid` the cycle after ack; `retired`=0 until the first commit.
- Sequential flow:
  - Stimulus: return `npc`=`pc`+1 each time, with `LAST_PC`=3.
  - Required: fetch addresses 0,1,2,3; `halted`=1 after 4 commits; `retired`=4; no further `imem_req`.
- Taken branch:
  - Stimulus: at `pc`=2 return `npc`=9.
  - Required: next `imem_addr`=9; `instr` holds the word from address 9.
- Memory wait states:
  - Stimulus: delay `imem_ack` by 3 cycles and toggle `imem_rdata` before the ack.
  - Required: `imem_req` stays high for 4 cycles with `imem_addr` constant; `instr` equals the data present at the ack edge.
- Spurious inputs:
  - Stimulus: `npc_valid` during FETCH, `imem_ack` during EXEC, `start` during EXEC.
  - Required: state, `pc`, `instr` and `retired` are all unchanged.
- Reset mid-operation:
  - Stimulus: assert `rst` during FETCH at `pc`=5, then during HALT.
  - Required: next cycle `pc`=`RESET_PC`, `imem_req`=0, `halted`=0, `retired`=0, IDLE until `start`.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer: fetches each instruction over a req/ack
// handshake, holds it for execute, commits the returned next-PC and halts at LAST_PC.
module pc_sequencer #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned LAST_PC  = 59
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    output logic            o_imem_req,
    output logic [PC_W-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [31:0]     i_imem_rdata,
    output logic [PC_W-1:0] o_pc,
    output logic [31:0]     o_instr,
    output logic            o_instr_valid,
    input  logic [PC_W-1:0] i_npc,
    input  logic            i_npc_valid,
    output logic            o_halted,
    output logic [15:0]     o_retired
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned RET_W   = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [RET_W-1:0]   r_retired;
    logic               w_ack_take;
    logic               w_commit;
    logic               w_at_last;

    assign w_at_last = (r_pc == PC_W'(LAST_PC));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; handshake strobes are qualified by the owning state.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_take  = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (i_imem_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (i_npc_valid) begin
                    w_commit    = 1'b1;
                    w_state_nxt = w_at_last ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc      <= PC_W'(RESET_PC);
            r_instr   <= '0;
            r_retired <= '0;
        end else begin
            if (w_ack_take) begin
                r_instr <= i_imem_rdata;
            end
            if (w_commit) begin
                if (r_retired != {RET_W{1'b1}}) r_retired <= r_retired + RET_W'(1);
                if (!w_at_last) r_pc <= i_npc;
            end
        end
    end

    assign o_imem_req    = (r_state == S_FETCH);
    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = (r_state == S_EXEC);
    assign o_halted      = (r_state == S_HALT);
    assign o_retired     = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a cycle model of the sequencer rules checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_pc_sequencer;

    localparam int unsigned PC_W     = 10;
    localparam int unsigned RESET_PC = 0;
    localparam int unsigned LAST_PC  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            imem_ack = 1'b0;
    logic [31:0]     imem_rdata = 32'h0;
    logic [PC_W-1:0] npc = '0;
    logic            npc_valid = 1'b0;
    logic            o_imem_req;
    logic [PC_W-1:0] o_imem_addr;
    logic [PC_W-1:0] o_pc;
    logic [31:0]     o_instr;
    logic            o_instr_valid;
    logic            o_halted;
    logic [15:0]     o_retired;

    int tests = 0;
    int fails = 0;
    logic [PC_W-1:0] fetch_log[$];

    pc_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC), .LAST_PC(LAST_PC)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
        .o_pc(o_pc), .o_instr(o_instr), .o_instr_valid(o_instr_valid),
        .i_npc(npc), .i_npc_valid(npc_valid),
        .o_halted(o_halted), .o_retired(o_retired)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [PC_W-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 waiting for memory, 2 awaiting commit, 3 done.
    int          m_phase = 0;
    int          m_pc = RESET_PC;
    logic [31:0] m_instr = 32'h0;
    int          m_ret = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0; m_pc <= RESET_PC; m_instr <= 32'h0; m_ret <= 0;
        end else if (m_phase == 0 && start) begin
            m_phase <= 1;
        end else if (m_phase == 1 && imem_ack) begin
            m_instr <= imem_rdata;
            m_phase <= 2;
        end else if (m_phase == 2 && npc_valid) begin
            m_ret <= (m_ret < 65535) ? m_ret + 1 : m_ret;
            if (m_pc == int'(LAST_PC)) m_phase <= 3;
            else begin
                m_pc    <= int'(npc);
                m_phase <= 1;
            end
        end
    end

    always @(negedge clk) begin
        check("req", 32'(o_imem_req), 32'(m_phase == 1));
        check("valid", 32'(o_instr_valid), 32'(m_phase == 2));
        check("halted", 32'(o_halted), 32'(m_phase == 3));
        check("pc", 32'(o_pc), 32'(m_pc));
        check("instr", o_instr, m_instr);
        check("retired", 32'(o_retired), 32'(m_ret));
        if (o_imem_req) check("addr_eq_pc", 32'(o_imem_addr), 32'(o_pc));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch of address a after `waits` idle cycles; garbage data and a
    // spurious npc_valid are driven during the wait.
    task automatic do_fetch(input int waits, input logic [PC_W-1:0] a);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0; imem_rdata = $urandom; npc_valid = (i == 0); npc = 10'h07;
            check("wait_req", 32'(o_imem_req), 32'd1);
            check("wait_addr", 32'(o_imem_addr), 32'(a));
            tick();
        end
        npc_valid = 1'b0;
        check("ack_req", 32'(o_imem_req), 32'd1);
        check("ack_addr", 32'(o_imem_addr), 32'(a));
        fetch_log.push_back(o_imem_addr);
        imem_ack = 1'b1; imem_rdata = word(a);
        tick();
        imem_ack = 1'b0; imem_rdata = $urandom;
        check("lat_valid", 32'(o_instr_valid), 32'd1);
        check("lat_instr", o_instr, word(a));
    endtask

    // Hold execute for `stalls` cycles with spurious ack/start, then commit n.
    task automatic do_exec(input int stalls, input logic [PC_W-1:0] n);
        for (int i = 0; i < stalls; i++) begin
            imem_ack = 1'b1; start = 1'b1; imem_rdata = $urandom;
            check("stall_valid", 32'(o_instr_valid), 32'd1);
            tick();
        end
        imem_ack = 1'b0; start = 1'b0;
        npc_valid = 1'b1; npc = n;
        tick();
        npc_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_pc", 32'(o_pc), 32'd0);
        check("rst_req", 32'(o_imem_req), 32'd0);
        check("rst_ret", 32'(o_retired), 32'd0);
        tick();
        check("idle_req", 32'(o_imem_req), 32'd0);

        start = 1'b1; tick(); start = 1'b0;
        check("start_req", 32'(o_imem_req), 32'd1);
        check("start_addr", 32'(o_imem_addr), 32'd0);
        do_fetch(0, 10'd0);
        check("pre_commit_ret", 32'(o_retired), 32'd0);
        do_exec(0, 10'd1);
        check("ret1", 32'(o_retired), 32'd1);
        check("pc1", 32'(o_pc), 32'd1);
        do_fetch(0, 10'd1);
        do_exec(1, 10'd2);
        do_fetch(3, 10'd2);
        do_exec(2, 10'd9);
        check("ret_after_spurious", 32'(o_retired), 32'd3);
        check("branch_addr", 32'(o_imem_addr), 32'd9);
        do_fetch(0, 10'd9);
        check("branch_instr", o_instr, 32'hC0DE_0009);
        do_exec(0, 10'd5);
        check("pc5", 32'(o_pc), 32'd5);
        imem_ack = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        check("mid_rst_pc", 32'(o_pc), 32'd0);
        check("mid_rst_req", 32'(o_imem_req), 32'd0);
        check("mid_rst_ret", 32'(o_retired), 32'd0);
        check("mid_rst_halt", 32'(o_halted), 32'd0);
        tick(); tick();
        check("late_ack_req", 32'(o_imem_req), 32'd0);
        check("late_ack_instr", o_instr, 32'd0);
        imem_ack = 1'b0;

        fetch_log.delete();
        start = 1'b1; tick(); start = 1'b0;
        for (int a = 0; a < 4; a++) begin
            do_fetch(0, PC_W'(a));
            do_exec(0, (a == 3) ? 10'h3FF : PC_W'(a + 1));
        end
        check("seq_halted", 32'(o_halted), 32'd1);
        check("seq_ret", 32'(o_retired), 32'd4);
        check("seq_pc", 32'(o_pc), 32'd3);
        check("seq_nfetch", 32'(fetch_log.size()), 32'd4);
        for (int i = 0; i < fetch_log.size() && i < 4; i++)
            check("seq_fetch_addr", 32'(fetch_log[i]), 32'(i));
        start = 1'b1; imem_ack = 1'b1; npc_valid = 1'b1;
        tick(); tick(); tick();
        start = 1'b0; imem_ack = 1'b0; npc_valid = 1'b0;
        check("halt_no_req", 32'(o_imem_req), 32'd0);
        check("halt_sticky", 32'(o_halted), 32'd1);
        check("halt_ret", 32'(o_retired), 32'd4);

        rst = 1'b1; tick(); rst = 1'b0;
        check("halt_rst_halted", 32'(o_halted), 32'd0);
        check("halt_rst_pc", 32'(o_pc), 32'd0);
        check("halt_rst_ret", 32'(o_retired), 32'd0);
        tick(); tick();
        check("halt_rst_idle", 32'(o_imem_req), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("restart_req", 32'(o_imem_req), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
